// File: rtl/calc_key_entry.sv
// Keypad front end for the calculator: decodes debounced key pulses, builds two
// decimal operands and an operator, and hands them to the ALU over valid/ready.
module calc_key_entry #(
  parameter int WIDTH      = 32,
  parameter int MAX_DIGITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      key_pulse,
  input  logic             calc_ready,
  output logic             calc_valid,
  output logic [WIDTH-1:0] operand_a,
  output logic [WIDTH-1:0] operand_b,
  output logic [1:0]       op,
  output logic [WIDTH-1:0] disp_value,
  output logic             key_err
);

  localparam int CW = $clog2(MAX_DIGITS + 1);

  typedef enum logic [1:0] {S_A, S_OP, S_B, S_REQ} state_t;

  state_t           r_state, w_state_n;
  logic [WIDTH-1:0] r_a, r_b, r_disp, w_a_n, w_b_n, w_disp_n;
  logic [1:0]       r_op, w_op_n;
  logic [CW-1:0]    r_cnt, w_cnt_n;
  logic             r_valid, r_err, w_valid_n, w_err_n;

  logic [14:0]      w_low;
  logic             w_clr, w_multi, w_one, w_is_digit, w_is_op, w_is_eq;
  logic [3:0]       w_digit;
  logic [1:0]       w_opc;
  logic [WIDTH-1:0] w_base, w_acc;
  logic [CW-1:0]    w_acc_cnt;

  // Clear dominates; any two of the remaining keys in one cycle is a discard.
  assign w_clr      = key_pulse[15];
  assign w_low      = key_pulse[14:0];
  assign w_multi    = |(w_low & (w_low - 15'd1));
  assign w_one      = (|w_low) & ~w_multi & ~w_clr;
  assign w_is_digit = w_one & (|w_low[9:0]);
  assign w_is_op    = w_one & (|w_low[13:10]);
  assign w_is_eq    = w_one & w_low[14];

  always_comb begin
    w_digit = 4'd0;
    for (int i = 0; i < 10; i++)
      if (w_low[i]) w_digit = 4'(i);
    w_opc = 2'd0;
    for (int i = 0; i < 4; i++)
      if (w_low[10+i]) w_opc = 2'(i);
  end

  // Leading zeros are not significant, so they neither change the value nor use up a digit slot.
  assign w_base = (r_state == S_A) ? r_a : r_b;
  always_comb begin
    w_acc     = w_base;
    w_acc_cnt = r_cnt;
    if (r_cnt != CW'(MAX_DIGITS) && !(w_base == '0 && w_digit == 4'd0)) begin
      w_acc     = w_base * WIDTH'(10) + WIDTH'(w_digit);
      w_acc_cnt = r_cnt + CW'(1);
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_a_n     = r_a;
    w_b_n     = r_b;
    w_op_n    = r_op;
    w_cnt_n   = r_cnt;
    w_valid_n = r_valid;
    w_err_n   = w_multi & ~w_clr;
    if (w_clr) begin
      w_state_n = S_A;
      w_a_n     = '0;
      w_b_n     = '0;
      w_op_n    = 2'd0;
      w_cnt_n   = '0;
      w_valid_n = 1'b0;
    end else begin
      case (r_state)
        S_A: begin
          if (w_is_digit) begin
            w_a_n   = w_acc;
            w_cnt_n = w_acc_cnt;
          end else if (w_is_op) begin
            w_op_n    = w_opc;
            w_cnt_n   = '0;
            w_state_n = S_OP;
          end
        end
        S_OP: begin
          if (w_is_op) begin
            w_op_n = w_opc;
          end else if (w_is_digit) begin
            w_b_n     = WIDTH'(w_digit);
            w_cnt_n   = CW'(w_digit != 4'd0);
            w_state_n = S_B;
          end
        end
        S_B: begin
          if (w_is_digit) begin
            w_b_n   = w_acc;
            w_cnt_n = w_acc_cnt;
          end else if (w_is_eq) begin
            w_valid_n = 1'b1;
            w_state_n = S_REQ;
          end
        end
        S_REQ: begin
          if (r_valid && calc_ready) begin
            w_valid_n = 1'b0;
            w_a_n     = '0;
            w_b_n     = '0;
            w_cnt_n   = '0;
            w_state_n = S_A;
          end
        end
        default: w_state_n = S_A;
      endcase
    end
    w_disp_n = (w_state_n == S_B || w_state_n == S_REQ) ? w_b_n : w_a_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_A;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= 2'd0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_disp  <= '0;
    end else begin
      r_state <= w_state_n;
      r_a     <= w_a_n;
      r_b     <= w_b_n;
      r_op    <= w_op_n;
      r_cnt   <= w_cnt_n;
      r_valid <= w_valid_n;
      r_err   <= w_err_n;
      r_disp  <= w_disp_n;
    end
  end

  assign calc_valid = r_valid;
  assign operand_a  = r_a;
  assign operand_b  = r_b;
  assign op         = r_op;
  assign disp_value = r_disp;
  assign key_err    = r_err;

endmodule

// File: tb/tb_calc_key_entry.sv
// Table-driven bench for calc_key_entry: each record is one cycle of stimulus and
// the outputs expected after that edge, checked through an expectation queue.
module tb_calc_key_entry;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] key_pulse = '0;
  logic        calc_ready = 1'b0;
  logic        calc_valid;
  logic [31:0] operand_a, operand_b, disp_value;
  logic [1:0]  op;
  logic        key_err;

  calc_key_entry #(.WIDTH(32), .MAX_DIGITS(8)) dut (
    .clk(clk), .rst(rst), .key_pulse(key_pulse), .calc_ready(calc_ready),
    .calc_valid(calc_valid), .operand_a(operand_a), .operand_b(operand_b),
    .op(op), .disp_value(disp_value), .key_err(key_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [15:0] key;
    logic        rdy;
    logic        v;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] disp;
    logic        err;
  } vec_t;

  localparam logic [15:0] K_ADD = 16'h0400, K_SUB = 16'h0800, K_MUL = 16'h1000,
                          K_EQ = 16'h4000, K_CLR = 16'h8000;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic logic [15:0] dk(input int d);
    dk = 16'(1 << d);
  endfunction

  function automatic vec_t mk(input logic r, input logic [15:0] k, input logic rd,
                              input logic v, input logic [31:0] a, input logic [31:0] b,
                              input logic [1:0] o, input logic [31:0] d, input logic e);
    mk = '{rst: r, key: k, rdy: rd, v: v, a: a, b: b, op: o, disp: d, err: e};
  endfunction

  task automatic apply(input vec_t t, input int idx);
    vec_t e;
    rst        = t.rst;
    key_pulse  = t.key;
    calc_ready = t.rdy;
    exp_q.push_back(t);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    key_pulse  = '0;
    calc_ready = 1'b0;
    e = exp_q.pop_front();
    n_vec++;
    if (calc_valid !== e.v || operand_a !== e.a || operand_b !== e.b || op !== e.op ||
        disp_value !== e.disp || key_err !== e.err) begin
      n_bad++;
      $display("FAIL vec%0d key=%h: got v=%b a=%0d b=%0d op=%0d disp=%0d err=%b, want v=%b a=%0d b=%0d op=%0d disp=%0d err=%b",
               idx, e.key, calc_valid, operand_a, operand_b, op, disp_value, key_err,
               e.v, e.a, e.b, e.op, e.disp, e.err);
    end
  endtask

  initial begin
    int a9;
    // basic entry and one transfer
    tbl.push_back(mk(1, 16'h0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, dk(1), 0, 0, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, dk(2), 0, 0, 12, 0, 0, 12, 0));
    tbl.push_back(mk(0, dk(3), 0, 0, 123, 0, 0, 123, 0));
    tbl.push_back(mk(0, K_ADD, 0, 0, 123, 0, 0, 123, 0));
    tbl.push_back(mk(0, dk(4), 0, 0, 123, 4, 0, 4, 0));
    tbl.push_back(mk(0, dk(5), 0, 0, 123, 45, 0, 45, 0));
    tbl.push_back(mk(0, K_EQ, 0, 1, 123, 45, 0, 45, 0));
    tbl.push_back(mk(0, 16'h0, 0, 1, 123, 45, 0, 45, 0));
    tbl.push_back(mk(0, dk(9), 0, 1, 123, 45, 0, 45, 0));
    tbl.push_back(mk(0, K_SUB, 0, 1, 123, 45, 0, 45, 0));
    tbl.push_back(mk(0, 16'h0, 1, 0, 0, 0, 0, 0, 0));
    // operator overwrite in S_OP, equals ignored in S_A / S_OP
    tbl.push_back(mk(0, K_EQ, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, K_SUB, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, K_EQ, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, K_MUL, 0, 0, 0, 0, 2, 0, 0));
    tbl.push_back(mk(0, dk(7), 0, 0, 0, 7, 2, 7, 0));
    tbl.push_back(mk(0, K_ADD, 0, 0, 0, 7, 2, 7, 0));
    tbl.push_back(mk(0, K_EQ, 0, 1, 0, 7, 2, 7, 0));
    // clear aborts a pending request
    tbl.push_back(mk(0, K_CLR, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, dk(3), 0, 0, 3, 0, 0, 3, 0));
    tbl.push_back(mk(0, K_ADD, 0, 0, 3, 0, 0, 3, 0));
    tbl.push_back(mk(0, dk(2), 0, 0, 3, 2, 0, 2, 0));
    tbl.push_back(mk(0, K_EQ, 0, 1, 3, 2, 0, 2, 0));
    tbl.push_back(mk(0, K_CLR, 1, 0, 0, 0, 0, 0, 0));
    // leading zeros then digit cap
    tbl.push_back(mk(0, dk(0), 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, dk(0), 0, 0, 0, 0, 0, 0, 0));
    a9 = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) a9 = a9 * 10 + 9;
      tbl.push_back(mk(0, dk(9), 0, 0, a9, 0, 0, a9, 0));
    end
    tbl.push_back(mk(0, dk(0), 0, 0, 99999999, 0, 0, 99999999, 0));
    // multi-key discard and clear dominance
    tbl.push_back(mk(0, 16'h0006, 0, 0, 99999999, 0, 0, 99999999, 1));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 99999999, 0, 0, 99999999, 0));
    tbl.push_back(mk(0, 16'h4400, 0, 0, 99999999, 0, 0, 99999999, 1));
    tbl.push_back(mk(0, 16'h8006, 0, 0, 0, 0, 0, 0, 0));
    // reset mid operand_b
    tbl.push_back(mk(0, dk(1), 0, 0, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, K_SUB, 0, 0, 1, 0, 1, 1, 0));
    tbl.push_back(mk(0, dk(5), 0, 0, 1, 5, 1, 5, 0));
    tbl.push_back(mk(0, dk(6), 0, 0, 1, 56, 1, 56, 0));
    tbl.push_back(mk(0, K_MUL, 0, 0, 1, 56, 1, 56, 0));
    tbl.push_back(mk(1, dk(7), 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, dk(4), 0, 0, 4, 0, 0, 4, 0));
    tbl.push_back(mk(0, dk(2), 0, 0, 42, 0, 0, 42, 0));

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // hand sequence: ready raised several cycles after valid, op kept after transfer
    apply(mk(0, K_DIV(), 0, 0, 42, 0, 3, 42, 0), 1000);
    apply(mk(0, dk(8), 0, 0, 42, 8, 3, 8, 0), 1001);
    apply(mk(0, K_EQ, 1, 1, 42, 8, 3, 8, 0), 1002);
    for (int i = 0; i < 3; i++) apply(mk(0, 16'h0, 0, 1, 42, 8, 3, 8, 0), 1003 + i);
    apply(mk(0, 16'h0, 1, 0, 0, 0, 3, 0, 0), 1006);
    apply(mk(0, dk(5), 1, 0, 5, 0, 3, 5, 0), 1007);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  function automatic logic [15:0] K_DIV();
    K_DIV = 16'h2000;
  endfunction

endmodule
